// File: rtl/vga_pkg.sv
// Shared constants, mode encodings and colour helpers for the VGA pattern scheduler.
package vga_pkg;

  localparam int H_ACT = 800;
  localparam int V_ACT = 600;
  localparam int BOX   = 64;
  localparam int STEP  = 4;
  localparam int CDIV  = 30;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] BLUE  = 8'h03;

  // Which 100-pixel-wide bar a column falls into (0..7 across the active line).
  function automatic logic [2:0] bar_index(input logic [10:0] h);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h >= 11'(i * 100)) idx = 3'(i);
    end
    return idx;
  endfunction

  // Colour bar: each index bit drives one whole RGB332 channel fully on or off.
  function automatic logic [7:0] bar_colour(input logic [2:0] i);
    return {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
  endfunction

endpackage

// File: rtl/vga_pattern_sched_if.sv
// Timing, key and pixel-code signals between the VGA driver side and the scheduler.
interface vga_pattern_sched_if;
  logic        frame_start;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        de;
  logic        key_next;
  logic        key_pause;
  logic [7:0]  en;
  logic [1:0]  mode;
  logic        paused;

  modport master (
    output frame_start, hcnt, vcnt, de, key_next, key_pause,
    input  en, mode, paused
  );

  modport slave (
    input  frame_start, hcnt, vcnt, de, key_next, key_pause,
    output en, mode, paused
  );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing box position: moves STEP pixels per enabled frame on each axis, reflecting at the edges.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  output logic [10:0] box_x,
  output logic [9:0]  box_y
);

  localparam logic [11:0] BOX12  = 12'(BOX);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] XLIM12 = 12'(H_ACT);
  localparam logic [11:0] YLIM12 = 12'(V_ACT);

  // dir bits: 0 = moving towards larger coordinates, 1 = moving back towards 0
  logic        dir_x, dir_y;
  logic [11:0] x_ext, y_ext;

  assign x_ext = {1'b0, box_x};
  assign y_ext = {2'b0, box_y};

  // Advance both axes once per enabled frame, clamping to the wall and reversing on contact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else if (step_en) begin
      if (!dir_x) begin
        if (x_ext + BOX12 + STEP12 > XLIM12) begin
          box_x <= 11'(H_ACT - BOX);
          dir_x <= 1'b1;
        end else begin
          box_x <= box_x + 11'(STEP);
        end
      end else if (x_ext < STEP12) begin
        box_x <= '0;
        dir_x <= 1'b0;
      end else begin
        box_x <= box_x - 11'(STEP);
      end

      if (!dir_y) begin
        if (y_ext + BOX12 + STEP12 > YLIM12) begin
          box_y <= 10'(V_ACT - BOX);
          dir_y <= 1'b1;
        end else begin
          box_y <= box_y + 10'(STEP);
        end
      end else if (y_ext < STEP12) begin
        box_y <= '0;
        dir_y <= 1'b0;
      end else begin
        box_y <= box_y - 10'(STEP);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler: mode selection, animation state and registered pixel mux.
module vga_pattern_sched
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  vga_pattern_sched_if.slave bus
);

  mode_t       state, state_nxt;
  logic        req;
  logic        paused_q;
  logic [7:0]  colour;
  logic [4:0]  div;
  logic [7:0]  en_q;
  logic [7:0]  pix;
  logic [10:0] box_x;
  logic [9:0]  box_y;
  logic        advance;
  logic        anim_step;
  logic        in_box;
  logic [11:0] hx, vy, bx, by;

  // A request raised in the very cycle of frame_start still counts for that frame.
  assign advance   = bus.frame_start & (req | bus.key_next);
  assign anim_step = bus.frame_start & ~paused_q;

  vga_box_mover u_box (
    .clk     (clk),
    .rst     (rst),
    .step_en (anim_step),
    .box_x   (box_x),
    .box_y   (box_y)
  );

  // Mode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MODE_BARS;
    else     state <= state_nxt;
  end

  // Step to the next pattern only when a pending request meets a frame boundary.
  always_comb begin
    state_nxt = state;
    if (advance) begin
      case (state)
        MODE_BARS:  state_nxt = MODE_CHECK;
        MODE_CHECK: state_nxt = MODE_BOX;
        MODE_BOX:   state_nxt = MODE_SOLID;
        MODE_SOLID: state_nxt = MODE_BARS;
      endcase
    end
  end

  // Mode output is the state itself.
  always_comb begin
    bus.mode = state;
  end

  // Sticky request: any number of key_next pulses within a frame collapse into one advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  req <= 1'b0;
    else if (bus.frame_start) req <= 1'b0;
    else if (bus.key_next)    req <= 1'b1;
  end

  // Pause toggles immediately on each key press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                paused_q <= 1'b0;
    else if (bus.key_pause) paused_q <= ~paused_q;
  end

  // Solid colour bumps once every CDIV animated frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      colour <= '0;
    end else if (anim_step) begin
      if (div == 5'(CDIV - 1)) begin
        div    <= '0;
        colour <= colour + 8'd1;
      end else begin
        div <= div + 5'd1;
      end
    end
  end

  assign hx = {1'b0, bus.hcnt};
  assign vy = {2'b0, bus.vcnt};
  assign bx = {1'b0, box_x};
  assign by = {2'b0, box_y};
  assign in_box = (hx >= bx) && (hx < bx + 12'(BOX)) && (vy >= by) && (vy < by + 12'(BOX));

  // Pattern generator for the current pixel; blanking always forces black.
  always_comb begin
    pix = BLACK;
    if (bus.de) begin
      case (state)
        MODE_BARS:  pix = bar_colour(bar_index(bus.hcnt));
        MODE_CHECK: pix = (bus.hcnt[5] ^ bus.vcnt[5]) ? WHITE : BLACK;
        MODE_BOX:   pix = in_box ? RED : BLUE;
        MODE_SOLID: pix = colour;
      endcase
    end
  end

  // One-cycle registered pixel path towards the rgb stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= BLACK;
    else     en_q <= pix;
  end

  assign bus.en     = en_q;
  assign bus.paused = paused_q;

endmodule
